// File: rtl/darksoc_dbgtrace_pkg.sv
// darksoc_dbg_pkg: shared configuration and record type for the debug trace stage.
//   NCH  - number of monitored DEBUG channels
//   DW   - width of one DEBUG channel
//   TSW  - timestamp width
//   CHW  - channel index width, clog2(NCH)
//   dbgtrace_rec_t - one trace record {ch, data, ts, ovr}, the FIFO entry type
package darksoc_dbg_pkg;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TSW = 32;
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic [DW-1:0]  data;
    logic [TSW-1:0] ts;
    logic           ovr;
  } dbgtrace_rec_t;

endpackage

// File: rtl/darksoc_dbgtrace_if.sv
// darksoc_dbgtrace_if: valid/ready trace record stream.
//   TRACE_VALID - head record valid            (master -> slave)
//   TRACE_READY - consumer accepts the head     (slave -> master)
//   TRACE_CH    - channel index of the record   (master -> slave)
//   TRACE_DATA  - new channel value             (master -> slave)
//   TRACE_TS    - cycle stamp of the change     (master -> slave)
//   TRACE_OVR   - intermediate values were lost (master -> slave)
interface darksoc_dbgtrace_if;
  import darksoc_dbg_pkg::*;

  logic           TRACE_VALID;
  logic           TRACE_READY;
  logic [CHW-1:0] TRACE_CH;
  logic [DW-1:0]  TRACE_DATA;
  logic [TSW-1:0] TRACE_TS;
  logic           TRACE_OVR;

  modport master (
    output TRACE_VALID, TRACE_CH, TRACE_DATA, TRACE_TS, TRACE_OVR,
    input  TRACE_READY
  );

  modport slave (
    input  TRACE_VALID, TRACE_CH, TRACE_DATA, TRACE_TS, TRACE_OVR,
    output TRACE_READY
  );

endinterface

// File: rtl/darksoc_dbgtrace_fifo.sv
// darksoc_dbgtrace_fifo: registered synchronous FIFO of dbgtrace_rec_t, no fall-through.
//   clk, rst - clock and synchronous active-high reset (pointers only)
//   push     - write rec_in (ignored when full unless a pop happens the same edge)
//   rec_in   - record to write
//   pop      - remove the head (ignored when empty)
//   rec_out  - head record, forced to zero while empty
//   valid    - FIFO holds at least one record
//   full     - FIFO holds DEPTH records
module darksoc_dbgtrace_fifo
  import darksoc_dbg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  dbgtrace_rec_t rec_in,
  input  logic          pop,
  output dbgtrace_rec_t rec_out,
  output logic          valid,
  output logic          full
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [AW:0] PONE = {{AW{1'b0}}, 1'b1};

  dbgtrace_rec_t r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_pop;
  logic          w_push;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign valid  = (r_wptr != r_rptr);
  assign full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop  = pop && valid;
  assign w_push = push && (!full || w_pop);

  // Storage is never reset; gating keeps the head at zero while empty.
  assign rec_out = valid ? r_mem[r_rptr[AW-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PONE;
      if (w_pop)  r_rptr <= r_rptr + PONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= rec_in;
  end

endmodule

// File: rtl/darksoc_dbgtrace.sv
// darksoc_dbgtrace: per-channel change detector and timestamped trace FIFO for the
// darksoc DEBUG bus.
//   XCLK     - core clock
//   XRES     - synchronous active-high reset
//   DEBUG    - NCH x DW monitored debug words
//   TRACE_EN - capture enable; shadows keep tracking DEBUG while low
//   trc      - trace record stream (darksoc_dbgtrace_if.master)
//   FULL     - trace FIFO full
//   DROP_CNT - saturating count of overwritten (lost) intermediate values
// Build option: define DBGTRACE_TIMESTAMP_EN to include the cycle counter and per-channel
// stamps; otherwise TRACE_TS is constant zero.
module darksoc_dbgtrace
  import darksoc_dbg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    XCLK,
  input  logic                    XRES,
  input  logic [NCH-1:0][DW-1:0]  DEBUG,
  input  logic                    TRACE_EN,
  darksoc_dbgtrace_if.master      trc,
  output logic                    FULL,
  output logic [15:0]             DROP_CNT
);

  localparam int CNTW = $clog2(NCH + 1);

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [CNTW-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic                   r_primed;
  logic [NCH-1:0][DW-1:0] r_shadow;
  logic [NCH-1:0][DW-1:0] r_pval;
  logic [NCH-1:0]         r_pend;
  logic [NCH-1:0]         r_povr;
  logic [15:0]            r_drop;
`ifdef DBGTRACE_TIMESTAMP_EN
  logic [TSW-1:0]           r_cnt;
  logic [NCH-1:0][TSW-1:0]  r_pts;
`endif

  logic [NCH-1:0] w_chg;
  logic [NCH-1:0] w_drain;
  logic [NCH-1:0] w_ovf;
  logic [CNTW-1:0] w_ovf_n;
  logic [CHW-1:0] w_sel;
  logic           w_any;
  logic           w_push;
  logic           w_pop;
  logic           w_valid;
  logic           w_full;
  dbgtrace_rec_t  w_rec;
  dbgtrace_rec_t  w_head;

  // Fixed priority: scanning downwards leaves the lowest pending index selected.
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (r_pend[i]) begin
        w_sel = CHW'(i);
        w_any = 1'b1;
      end
    end
  end

  assign w_pop  = w_valid && trc.TRACE_READY;
  assign w_push = w_any && (!w_full || w_pop);

  always_comb begin
    w_chg   = '0;
    w_drain = '0;
    w_ovf   = '0;
    w_ovf_n = '0;
    for (int i = 0; i < NCH; i++) begin
      w_chg[i]   = r_primed && TRACE_EN && (DEBUG[i] != r_shadow[i]);
      w_drain[i] = w_push && (w_sel == CHW'(i));
      // Overrun only when the pending value is not leaving this very cycle.
      w_ovf[i]   = w_chg[i] && r_pend[i] && !w_drain[i];
      w_ovf_n    = w_ovf_n + CNTW'(w_ovf[i]);
    end
  end

  always_comb begin
    w_rec      = '0;
    w_rec.ch   = w_sel;
    w_rec.data = r_pval[w_sel];
`ifdef DBGTRACE_TIMESTAMP_EN
    w_rec.ts   = r_pts[w_sel];
`endif
    w_rec.ovr  = r_povr[w_sel];
  end

  // Data-path registers: shadows always follow DEBUG, pending values load on change.
  always_ff @(posedge XCLK) begin
    r_shadow <= DEBUG;
    for (int i = 0; i < NCH; i++) begin
      if (w_chg[i]) begin
        r_pval[i] <= DEBUG[i];
`ifdef DBGTRACE_TIMESTAMP_EN
        r_pts[i]  <= r_cnt;
`endif
      end
    end
  end

  // Control: priming, pending/overrun flags and drop counter.
  always_ff @(posedge XCLK) begin
    if (XRES) begin
      r_primed <= 1'b0;
      r_pend   <= '0;
      r_povr   <= '0;
      r_drop   <= '0;
    end else begin
      r_primed <= 1'b1;
      r_drop   <= sat_add16(r_drop, w_ovf_n);
      for (int i = 0; i < NCH; i++) begin
        if (w_chg[i]) begin
          r_pend[i] <= 1'b1;
          r_povr[i] <= w_ovf[i];
        end else if (w_drain[i]) begin
          r_pend[i] <= 1'b0;
          r_povr[i] <= 1'b0;
        end
      end
    end
  end

`ifdef DBGTRACE_TIMESTAMP_EN
  always_ff @(posedge XCLK) begin
    if (XRES) r_cnt <= '0;
    else      r_cnt <= r_cnt + TSW'(1);
  end
`endif

  // Record stage: one arbitrated record per cycle into the registered FIFO.
  darksoc_dbgtrace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (XCLK),
    .rst     (XRES),
    .push    (w_push),
    .rec_in  (w_rec),
    .pop     (w_pop),
    .rec_out (w_head),
    .valid   (w_valid),
    .full    (w_full)
  );

  assign trc.TRACE_VALID = w_valid;
  assign trc.TRACE_CH    = w_head.ch;
  assign trc.TRACE_DATA  = w_head.data;
  assign trc.TRACE_TS    = w_head.ts;
  assign trc.TRACE_OVR   = w_head.ovr;
  assign FULL            = w_full;
  assign DROP_CNT        = r_drop;

endmodule

// File: tb/tb_darksoc_dbgtrace.sv
module tb_darksoc_dbgtrace;
  import darksoc_dbg_pkg::*;

  localparam int NV = 33;
`ifdef DBGTRACE_TIMESTAMP_EN
  localparam logic [31:0] TSMASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] TSMASK = 32'h0;
`endif

  typedef struct {
    logic [3:0][31:0] dbg;
    logic             en;
    logic             rdy;
    logic             ev;
    logic [31:0]      ech;
    logic [31:0]      edata;
    logic [31:0]      ets;
    logic             eovr;
  } vec_t;

  logic             clk;
  logic             XRES;
  logic [3:0][31:0] DEBUG;
  logic             TRACE_EN;
  logic             FULL;
  logic [15:0]      DROP_CNT;

  darksoc_dbgtrace_if trc_if ();

  darksoc_dbgtrace #(.DEPTH(16)) dut (
    .XCLK     (clk),
    .XRES     (XRES),
    .DEBUG    (DEBUG),
    .TRACE_EN (TRACE_EN),
    .trc      (trc_if),
    .FULL     (FULL),
    .DROP_CNT (DROP_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  vec_t vec [NV];
  logic [31:0] q_data[$];
  logic [31:0] q_ts[$];
  logic [31:0] q_ch[$];
  logic        q_ovr[$];
  int t3c [20];

  function automatic logic [31:0] ets(input int c);
    return 32'(c) & TSMASK;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input int max_cyc);
    q_data.delete(); q_ts.delete(); q_ch.delete(); q_ovr.delete();
    trc_if.TRACE_READY = 1'b1;
    for (int k = 0; k < max_cyc; k++) begin
      if (trc_if.TRACE_VALID) begin
        q_data.push_back(trc_if.TRACE_DATA);
        q_ts.push_back(trc_if.TRACE_TS);
        q_ch.push_back(32'(trc_if.TRACE_CH));
        q_ovr.push_back(trc_if.TRACE_OVR);
      end
      step();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] cur;

    // Table for priming, first latency, simultaneous changes and TRACE_EN gating.
    cur[0] = 32'h1111_1111; cur[1] = 32'h2222_2222; cur[2] = 32'h0; cur[3] = 32'h3333_3333;
    for (int r = 0; r < NV; r++) begin
      case (r)
        10: cur[2] = 32'h0000_00A5;
        14: begin cur[0] = 32'hDEAD_0000; cur[1] = 32'hBEEF_0001; cur[3] = 32'h1234_5678; end
        20: cur[0] = 32'h1;
        21: cur[3] = 32'h2;
        22: cur[0] = 32'h3;
        23: cur[3] = 32'h4;
        29: cur[0] = 32'h5;
        default: ;
      endcase
      vec[r].dbg   = cur;
      vec[r].en    = (r >= 20 && r <= 23) ? 1'b0 : 1'b1;
      vec[r].rdy   = 1'b1;
      vec[r].ev    = 1'b0;
      vec[r].ech   = 32'd0;
      vec[r].edata = 32'd0;
      vec[r].ets   = 32'd0;
      vec[r].eovr  = 1'b0;
    end
    vec[12].ev = 1'b1; vec[12].ech = 2; vec[12].edata = 32'h0000_00A5; vec[12].ets = ets(10);
    vec[16].ev = 1'b1; vec[16].ech = 0; vec[16].edata = 32'hDEAD_0000; vec[16].ets = ets(14);
    vec[17].ev = 1'b1; vec[17].ech = 1; vec[17].edata = 32'hBEEF_0001; vec[17].ets = ets(14);
    vec[18].ev = 1'b1; vec[18].ech = 3; vec[18].edata = 32'h1234_5678; vec[18].ets = ets(14);
    vec[31].ev = 1'b1; vec[31].ech = 0; vec[31].edata = 32'h5;         vec[31].ets = ets(29);

    // Reset state
    XRES = 1'b1;
    TRACE_EN = 1'b1;
    trc_if.TRACE_READY = 1'b1;
    DEBUG = vec[0].dbg;
    step();
    step();
    chk("rst_valid", 32'(trc_if.TRACE_VALID), 0);
    chk("rst_full",  32'(FULL), 0);
    chk("rst_drop",  32'(DROP_CNT), 0);
    chk("rst_ch",    32'(trc_if.TRACE_CH), 0);
    chk("rst_data",  trc_if.TRACE_DATA, 0);
    chk("rst_ts",    trc_if.TRACE_TS, 0);
    chk("rst_ovr",   32'(trc_if.TRACE_OVR), 0);

    XRES = 1'b0;
    cyc = 0;
    for (int r = 0; r < NV; r++) begin
      DEBUG = vec[r].dbg;
      TRACE_EN = vec[r].en;
      trc_if.TRACE_READY = vec[r].rdy;
      chk($sformatf("vec%0d_valid", r), 32'(trc_if.TRACE_VALID), 32'(vec[r].ev));
      if (vec[r].ev) begin
        chk($sformatf("vec%0d_ch", r),   32'(trc_if.TRACE_CH), vec[r].ech);
        chk($sformatf("vec%0d_data", r), trc_if.TRACE_DATA, vec[r].edata);
        chk($sformatf("vec%0d_ts", r),   trc_if.TRACE_TS, vec[r].ets);
        chk($sformatf("vec%0d_ovr", r),  32'(trc_if.TRACE_OVR), 32'(vec[r].eovr));
      end
      step();
    end
    chk("tbl_drop", 32'(DROP_CNT), 0);

    // Back-pressure with overruns on channel 1
    trc_if.TRACE_READY = 1'b0;
    for (int k = 0; k < 20; k++) begin
      DEBUG[1] = 32'h100 + 32'(k);
      t3c[k] = cyc;
      if (k == 16) chk("t3_full_before", 32'(FULL), 0);
      if (k == 17) chk("t3_full_at16", 32'(FULL), 1);
      step();
    end
    chk("t3_full",      32'(FULL), 1);
    chk("t3_drop",      32'(DROP_CNT), 3);
    chk("t3_head_vld",  32'(trc_if.TRACE_VALID), 1);
    chk("t3_head_data", trc_if.TRACE_DATA, 32'h100);
    drain(25);
    chk("t3_count", q_data.size(), 17);
    if (q_data.size() == 17) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("t3_rec%0d_data", i), q_data[i], 32'h100 + 32'(i));
        chk($sformatf("t3_rec%0d_ovr", i), 32'(q_ovr[i]), 0);
      end
      chk("t3_rec0_ts",   q_ts[0], ets(t3c[0]));
      chk("t3_last_ch",   q_ch[16], 1);
      chk("t3_last_data", q_data[16], 32'h113);
      chk("t3_last_ovr",  32'(q_ovr[16]), 1);
      chk("t3_last_ts",   q_ts[16], ets(t3c[19]));
    end
    chk("t3_drop_after", 32'(DROP_CNT), 3);
    chk("t3_empty", 32'(trc_if.TRACE_VALID), 0);

    // Full FIFO: pop, push and a new change in one cycle
    trc_if.TRACE_READY = 1'b0;
    for (int k = 0; k < 17; k++) begin
      DEBUG[1] = 32'h200 + 32'(k);
      step();
    end
    chk("t4_full_pre", 32'(FULL), 1);
    trc_if.TRACE_READY = 1'b1;
    DEBUG[1] = 32'h211;
    step();
    trc_if.TRACE_READY = 1'b0;
    chk("t4_full_post", 32'(FULL), 1);
    chk("t4_drop",      32'(DROP_CNT), 3);
    chk("t4_head",      trc_if.TRACE_DATA, 32'h201);
    step();
    drain(25);
    chk("t4_count", q_data.size(), 17);
    if (q_data.size() == 17) begin
      chk("t4_first", q_data[0], 32'h201);
      chk("t4_r15",   q_data[15], 32'h210);
      chk("t4_last",  q_data[16], 32'h211);
      chk("t4_last_ovr", 32'(q_ovr[16]), 0);
    end
    chk("t4_drop_after", 32'(DROP_CNT), 3);

    // Reset with records queued
    trc_if.TRACE_READY = 1'b0;
    for (int k = 0; k < 5; k++) begin
      DEBUG[2] = 32'h300 + 32'(k);
      step();
    end
    step();
    chk("t6_pre_vld",  32'(trc_if.TRACE_VALID), 1);
    chk("t6_pre_data", trc_if.TRACE_DATA, 32'h300);
    XRES = 1'b1;
    step();
    chk("t6_rst_vld",  32'(trc_if.TRACE_VALID), 0);
    chk("t6_rst_drop", 32'(DROP_CNT), 0);
    chk("t6_rst_full", 32'(FULL), 0);
    chk("t6_rst_data", trc_if.TRACE_DATA, 0);
    XRES = 1'b0;
    cyc = 0;
    trc_if.TRACE_READY = 1'b1;
    DEBUG[1] = 32'h400;
    step();
    while (cyc < 6) begin
      chk($sformatf("t6_idle%0d", cyc), 32'(trc_if.TRACE_VALID), 0);
      step();
    end
    DEBUG[3] = 32'h500;
    step();
    chk("t6_lat1", 32'(trc_if.TRACE_VALID), 0);
    step();
    chk("t6_vld",  32'(trc_if.TRACE_VALID), 1);
    chk("t6_ch",   32'(trc_if.TRACE_CH), 3);
    chk("t6_data", trc_if.TRACE_DATA, 32'h500);
    chk("t6_ts",   trc_if.TRACE_TS, ets(6));
    chk("t6_ovr",  32'(trc_if.TRACE_OVR), 0);
    step();
    chk("t6_done", 32'(trc_if.TRACE_VALID), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
